cpu_sequencer: RTL and testbench

Multi-cycle control FSM for the 32-bit processor datapath. It owns the program counter and steps each instruction through fetch, decode, execute, memory and write-back. It drives the register-bank write enable, flag-register update, RAM read/write flag and the LDR/address bus mux selects. It sits beside the register bank, ALU, flags register, memory control and RAM, and turns their combinational paths into a clocked machine.

---
 rtl/cpu_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/memory/write-back control FSM and program counter.
// Define CPU_SEQ_RAM_READY_EN to add the ram_ready handshake that stretches FETCH and MEM.
module cpu_sequencer #(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [31:0]     instr,
   input  logic [3:0]      flags,
`ifdef CPU_SEQ_RAM_READY_EN
   input  logic            ram_ready,
`endif
   output logic [PC_W-1:0] pc,
   output logic            ir_load,
   output logic            reg_we,
   output logic            flags_we,
   output logic            ram_rw,
   output logic            sel_add,
   output logic            sel_ldr,
   output logic            busy,
   output logic            halted,
   output logic [31:0]     retired
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_t;

   localparam logic [3:0] OP_LDR  = 4'b1000;
   localparam logic [3:0] OP_STR  = 4'b1001;
   localparam logic [3:0] OP_B    = 4'b1010;
   localparam logic [3:0] OP_HALT = 4'b1111;

   state_t          state_r;
   state_t          state_s;
   logic [PC_W-1:0] pc_r;
   logic [PC_W-1:0] pc_s;
   logic [PC_W-1:0] pc_inc_s;
   logic [PC_W-1:0] target_s;
   logic [31:0]     retired_r;
   logic            retire_s;
   logic [8:0]      ir_hi_r;
   logic [15:0]     im_r;
   logic [3:0]      cond_s;
   logic [3:0]      op_s;
   logic            s_bit_s;
   logic            ready_s;
   logic            ir_load_r;
   logic            reg_we_r;
   logic            flags_we_r;
   logic            ram_rw_r;
   logic            sel_add_r;
   logic            sel_ldr_r;
   logic            busy_r;
   logic            halted_r;
   logic            unused_instr_s;

   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v, res;
      n = nzcv[3];
      z = nzcv[2];
      c = nzcv[1];
      v = nzcv[0];
      case (cond)
         4'd0:    res = 1'b1;
         4'd1:    res = z;
         4'd2:    res = ~z;
         4'd3:    res = c;
         4'd4:    res = ~c;
         4'd5:    res = n;
         4'd6:    res = ~n;
         4'd7:    res = v;
         4'd8:    res = ~v;
         4'd9:    res = c & ~z;
         4'd10:   res = ~c | z;
         4'd11:   res = (n == v);
         4'd12:   res = (n != v);
         4'd13:   res = ~z & (n == v);
         4'd14:   res = z | (n != v);
         default: res = 1'b0;
      endcase
      return res;
   endfunction

`ifdef CPU_SEQ_RAM_READY_EN
   assign ready_s = ram_ready;
   assign ir_load = ir_load_r & ram_ready;
`else
   assign ready_s = 1'b1;
   assign ir_load = ir_load_r;
`endif

   assign cond_s         = ir_hi_r[8:5];
   assign op_s           = ir_hi_r[4:1];
   assign s_bit_s        = ir_hi_r[0];
   assign pc_inc_s       = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
   assign target_s       = im_r[PC_W-1:0];
   assign unused_instr_s = ^{instr[22:19], instr[2:0]};

   // Next state, next pc and retire strobe from the current state and latched instruction.
   always_comb begin
      state_s  = state_r;
      pc_s     = pc_r;
      retire_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) state_s = ST_FETCH;
            else       state_s = ST_IDLE;
         end
         ST_FETCH: begin
            if (ready_s) state_s = ST_DECODE;
            else         state_s = ST_FETCH;
         end
         ST_DECODE: begin
            if (op_s == OP_HALT) begin
               state_s = ST_HALT;
            end else if (!cond_pass(cond_s, flags)) begin
               state_s  = ST_FETCH;
               pc_s     = pc_inc_s;
               retire_s = 1'b1;
            end else begin
               state_s = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if ((op_s == OP_LDR) || (op_s == OP_STR)) begin
               state_s = ST_MEM;
            end else if (op_s == OP_B) begin
               state_s  = ST_FETCH;
               pc_s     = target_s;
               retire_s = 1'b1;
            end else begin
               state_s = ST_WB;
            end
         end
         ST_MEM: begin
            if (!ready_s) begin
               state_s = ST_MEM;
            end else if (op_s == OP_STR) begin
               state_s  = ST_FETCH;
               pc_s     = pc_inc_s;
               retire_s = 1'b1;
            end else begin
               state_s = ST_WB;
            end
         end
         ST_WB: begin
            state_s  = ST_FETCH;
            pc_s     = pc_inc_s;
            retire_s = 1'b1;
         end
         ST_HALT: begin
            state_s = ST_HALT;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, pc, retire counter, instruction latch and strobes registered from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         pc_r       <= RESET_PC;
         retired_r  <= 32'd0;
         ir_hi_r    <= 9'd0;
         im_r       <= 16'd0;
         ir_load_r  <= 1'b0;
         reg_we_r   <= 1'b0;
         flags_we_r <= 1'b0;
         ram_rw_r   <= 1'b0;
         sel_add_r  <= 1'b0;
         sel_ldr_r  <= 1'b0;
         busy_r     <= 1'b0;
         halted_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         pc_r    <= pc_s;
         if (retire_s) retired_r <= retired_r + 32'd1;
         if ((state_r == ST_FETCH) && ready_s) begin
            ir_hi_r <= instr[31:23];
            im_r    <= instr[18:3];
         end
         // Instruction fields are stable from DECODE on, so they can qualify the next-state strobes.
         ir_load_r  <= (state_s == ST_FETCH);
         sel_add_r  <= (state_s == ST_MEM);
         ram_rw_r   <= (state_s == ST_MEM) && (op_s == OP_STR);
         sel_ldr_r  <= ((state_s == ST_MEM) || (state_s == ST_WB)) && (op_s == OP_LDR);
         reg_we_r   <= (state_s == ST_WB);
         flags_we_r <= (state_s == ST_WB) && (op_s != OP_LDR) && s_bit_s;
         busy_r     <= (state_s != ST_IDLE) && (state_s != ST_HALT);
         halted_r   <= (state_s == ST_HALT);
      end
   end

   assign pc       = pc_r;
   assign retired  = retired_r;
   assign reg_we   = reg_we_r;
   assign flags_we = flags_we_r;
   assign ram_rw   = ram_rw_r;
   assign sel_add  = sel_add_r;
   assign sel_ldr  = sel_ldr_r;
   assign busy     = busy_r;
   assign halted   = halted_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized self-checking bench for cpu_sequencer against an instruction-level cycle-plan model.
module tb_cpu_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] instr;
   logic [3:0]  flags;
`ifdef CPU_SEQ_RAM_READY_EN
   logic        ram_ready;
`endif
   logic [15:0] pc;
   logic        ir_load, reg_we, flags_we, ram_rw, sel_add, sel_ldr, busy, halted;
   logic [31:0] retired;

   localparam logic [7:0] IRL = 8'h80;
   localparam logic [7:0] RWE = 8'h40;
   localparam logic [7:0] FWE = 8'h20;
   localparam logic [7:0] RRW = 8'h10;
   localparam logic [7:0] SAD = 8'h08;
   localparam logic [7:0] SLD = 8'h04;
   localparam logic [7:0] BSY = 8'h02;
   localparam logic [7:0] HLT = 8'h01;

   typedef struct packed {
      logic [7:0] sig;
      logic       rdy;
   } exp_t;

   logic [31:0] prog [64];
   exp_t        plan [$];
   logic [15:0] m_pc;
   logic [31:0] m_ret;
   int          total;
   int          bad;
   bit          h;
   logic [7:0]  obs;

   assign instr = prog[pc[5:0]];
   assign obs   = {ir_load, reg_we, flags_we, ram_rw, sel_add, sel_ldr, busy, halted};

   cpu_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
      .clk(clk), .reset(reset), .start(start), .instr(instr), .flags(flags),
`ifdef CPU_SEQ_RAM_READY_EN
      .ram_ready(ram_ready),
`endif
      .pc(pc), .ir_load(ir_load), .reg_we(reg_we), .flags_we(flags_we), .ram_rw(ram_rw),
      .sel_add(sel_add), .sel_ldr(sel_ldr), .busy(busy), .halted(halted), .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'd0:  return 1'b1;
         4'd1:  return z;
         4'd2:  return !z;
         4'd3:  return cy;
         4'd4:  return !cy;
         4'd5:  return n;
         4'd6:  return !n;
         4'd7:  return v;
         4'd8:  return !v;
         4'd9:  return cy && !z;
         4'd10: return !cy || z;
         4'd11: return n == v;
         4'd12: return n != v;
         4'd13: return !z && (n == v);
         4'd14: return z || (n != v);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] op,
                                      input logic s, input logic [15:0] im);
      logic [31:0] r;
      r = $urandom;
      r[31:28] = c;
      r[27:24] = op;
      r[23]    = s;
      r[18:3]  = im;
      return r;
   endfunction

   function automatic logic [3:0] rand_alu();
      logic [3:0] o;
      o = 4'($urandom_range(0, 11));
      if (o >= 4'd8) o = o + 4'd3;
      return o;
   endfunction

   task automatic push(input logic [7:0] s, input logic r);
      exp_t e;
      e.sig = s;
      e.rdy = r;
      plan.push_back(e);
   endtask

   task automatic push_ram(input logic [7:0] wait_sig, input logic [7:0] done_sig);
`ifdef CPU_SEQ_RAM_READY_EN
      int w;
      w = $urandom_range(0, 3);
      for (int i = 0; i < w; i++) push(wait_sig, 1'b0);
`else
      if (wait_sig == 8'hFF) push(wait_sig, 1'b0);
`endif
      push(done_sig, 1'b1);
   endtask

   task automatic drive_plan();
      exp_t e;
      while (plan.size() > 0) begin
         e = plan.pop_front();
`ifdef CPU_SEQ_RAM_READY_EN
         ram_ready = e.rdy;
`endif
         start = 1'($urandom_range(0, 1));
         @(negedge clk);
         check_eq("strobes", {24'd0, obs}, {24'd0, e.sig});
         check_eq("pc", {16'd0, pc}, {16'd0, m_pc});
         check_eq("retired", retired, m_ret);
         @(posedge clk); #1;
      end
   endtask

   // Executes the instruction at the model pc: builds its cycle plan, checks it, then advances the model.
   task automatic run_instr(input logic [3:0] f, output bit hit_halt);
      logic [31:0] w;
      logic [3:0]  op;
      logic [15:0] nxt;
      bit          ret;
      w = prog[m_pc[5:0]];
      op = w[27:24];
      flags = f;
      hit_halt = 1'b0;
      ret = 1'b1;
      nxt = m_pc + 16'd1;
      push_ram(BSY, IRL | BSY);
      push(BSY, 1'($urandom_range(0, 1)));
      if (op == 4'hF) begin
         hit_halt = 1'b1;
         ret = 1'b0;
         nxt = m_pc;
      end else if (cond_ok(w[31:28], f)) begin
         push(BSY, 1'($urandom_range(0, 1)));
         case (op)
            4'h8: begin
               push_ram(SAD | SLD | BSY, SAD | SLD | BSY);
               push(RWE | SLD | BSY, 1'($urandom_range(0, 1)));
            end
            4'h9: push_ram(SAD | RRW | BSY, SAD | RRW | BSY);
            4'hA: nxt = w[18:3];
            default: push(RWE | (w[23] ? FWE : 8'h00) | BSY, 1'($urandom_range(0, 1)));
         endcase
      end
      drive_plan();
      m_pc = nxt;
      if (ret) m_ret = m_ret + 32'd1;
      if (hit_halt) begin
         for (int i = 0; i < 3; i++) begin
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("halt_strobes", {24'd0, obs}, {24'd0, HLT});
            check_eq("halt_pc", {16'd0, pc}, {16'd0, m_pc});
            check_eq("halt_retired", retired, m_ret);
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      flags = 4'd0;
`ifdef CPU_SEQ_RAM_READY_EN
      ram_ready = 1'b1;
`endif
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      m_pc = 16'h0000;
      m_ret = 32'd0;
      @(negedge clk);
      check_eq("reset_strobes", {24'd0, obs}, 32'd0);
      check_eq("reset_pc", {16'd0, pc}, 32'd0);
      check_eq("reset_retired", retired, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic begin_run();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   initial begin
      total = 0;
      bad = 0;
      for (int i = 0; i < 64; i++) prog[i] = mk(4'd0, 4'hF, 1'b0, 16'd0);

      // ALU op with s_bit then HALT
      do_reset();
      prog[0] = mk(4'd0, rand_alu(), 1'b1, 16'($urandom));
      prog[1] = mk(4'($urandom), 4'hF, 1'b0, 16'($urandom));
      begin_run();
      run_instr(4'($urandom), h);
      run_instr(4'($urandom), h);
      check_eq("alu_halt_seen", {31'd0, h}, 32'd1);
      check_eq("alu_halt_pc", {16'd0, pc}, 32'd1);
      check_eq("alu_halt_retired", retired, 32'd1);

      // Directed path: LDR at 5, STR, conditional branches, wrap at 0xFFFF
      do_reset();
      prog[0]  = mk(4'd0, rand_alu(), 1'($urandom), 16'($urandom));
      prog[1]  = mk(4'd0, 4'hA, 1'b0, 16'h0005);
      prog[5]  = mk(4'd0, 4'h8, 1'b0, 16'($urandom));
      prog[6]  = mk(4'd0, 4'h9, 1'b0, 16'($urandom));
      prog[7]  = mk(4'd1, 4'hA, 1'b0, 16'h1234);
      prog[52] = prog[7];
      prog[53] = mk(4'd0, 4'hA, 1'b0, 16'hFFFF);
      prog[63] = mk(4'd15, 4'hA, 1'b0, 16'h0042);
      begin_run();
      for (int i = 0; i < 8; i++) begin
         if (i == 4)      run_instr(4'($urandom) | 4'b0100, h);
         else if (i == 5) run_instr(4'($urandom) & 4'b1011, h);
         else             run_instr(4'($urandom), h);
         if (i == 4) check_eq("beq_taken_pc", {16'd0, pc}, 32'h1234);
         if (i == 5) check_eq("beq_skip_pc", {16'd0, pc}, 32'h1235);
      end
      check_eq("wrap_pc", {16'd0, pc}, 32'h0000);
      check_eq("directed_retired", retired, 32'd8);

      // Reset during MEM of a STR
      do_reset();
      prog[0] = mk(4'd0, rand_alu(), 1'b0, 16'($urandom));
      prog[1] = mk(4'd0, 4'h9, 1'b0, 16'($urandom));
      begin_run();
      run_instr(4'($urandom), h);
`ifdef CPU_SEQ_RAM_READY_EN
      ram_ready = 1'b1;
`endif
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      check_eq("str_mem_strobes", {24'd0, obs}, {24'd0, SAD | RRW | BSY});
      reset = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check_eq("abort_strobes", {24'd0, obs}, 32'd0);
      check_eq("abort_pc", {16'd0, pc}, 32'd0);
      check_eq("abort_retired", retired, 32'd0);
      @(posedge clk); #1;

      // Random programs
      for (int p = 0; p < 25; p++) begin
         do_reset();
         for (int i = 0; i < 64; i++) begin
            int v;
            logic [3:0] c;
            v = $urandom_range(0, 11);
            c = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            case (v)
               4, 5:    prog[i] = mk(c, 4'h8, 1'($urandom), 16'($urandom));
               6, 9:    prog[i] = mk(c, 4'h9, 1'($urandom), 16'($urandom));
               7, 8:    prog[i] = mk(c, 4'hA, 1'($urandom), 16'($urandom));
               10:      prog[i] = mk(c, 4'hF, 1'($urandom), 16'($urandom));
               default: prog[i] = mk(c, rand_alu(), 1'($urandom), 16'($urandom));
            endcase
         end
         begin_run();
         h = 1'b0;
         for (int k = 0; k < 40 && !h; k++) run_instr(4'($urandom), h);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
